// File: rtl/iob_dma_read_mc.sv
// Multi-channel DMA read request engine: per-channel burst splitting, round-robin arbitration.
// Define IOB_DMA_READ_MC_4K_SPLIT_EN to keep every burst inside one 4 KiB page.
module iob_dma_read_mc #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int RLEN_W = 16
) (
    input  logic                                      clk_i,
    input  logic                                      cke_i,
    input  logic                                      rst_n_i,
    input  logic [N_CH-1:0]                           start_i,
    input  logic [N_CH-1:0]                           abort_i,
    input  logic [N_CH*ADDR_W-1:0]                    addr_i,
    input  logic [N_CH*RLEN_W-1:0]                    length_i,
    input  logic [LEN_W:0]                            max_len_i,
    input  logic [N_CH*(LEN_W+1)-1:0]                 space_i,
    output logic [N_CH-1:0]                           busy_o,
    output logic [N_CH-1:0]                           done_o,
    output logic [N_CH*RLEN_W-1:0]                    remaining_o,
    output logic                                      req_valid_o,
    input  logic                                      req_ready_i,
    output logic [ADDR_W-1:0]                         req_addr_o,
    output logic [LEN_W:0]                            req_len_o,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] req_ch_o,
    input  logic [N_CH-1:0]                           burst_done_i
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW    = (RLEN_W > 13) ? RLEN_W + 1 : 14;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

`ifdef IOB_DMA_READ_MC_4K_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ELIG = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Next burst length: remaining beats, clipped to the cap (0 means 1) and optionally the page end.
    function automatic logic [LEN_W:0] cand_len(input logic [RLEN_W-1:0] rem,
                                                input logic [LEN_W:0]    cap_in,
                                                input logic [11:0]       off);
        logic [CW-1:0] l, cap, bnd;
        cap = (cap_in == '0) ? CW'(1) : CW'(cap_in);
        l   = (CW'(rem) < cap) ? CW'(rem) : cap;
        bnd = CW'(13'h1000 - {1'b0, off}) >> OFF_W;
        if (SPLIT_EN && (bnd < l)) l = bnd;
        return (LEN_W + 1)'(l);
    endfunction

    logic [1:0]        st      [N_CH];
    logic [ADDR_W-1:0] ch_addr [N_CH];
    logic [RLEN_W-1:0] ch_rem  [N_CH];
    logic [LEN_W:0]    cand    [N_CH];
    logic [N_CH-1:0]   abort_pend, done_q, elig, pend;

    logic              req_valid_p1;
    logic [ADDR_W-1:0] req_addr_p1;
    logic [LEN_W:0]    req_len_p1;
    logic [CH_W-1:0]   req_ch_p1;
    logic [CH_W-1:0]   rr_ptr;

    logic              hs, can_grant, grant;
    logic [CH_W-1:0]   grant_ch;

    assign hs        = req_valid_p1 && req_ready_i;
    assign can_grant = !req_valid_p1 || hs;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign cand[g] = cand_len(ch_rem[g], max_len_i, ch_addr[g][11:0]);
        assign pend[g] = req_valid_p1 && (req_ch_p1 == CH_W'(g));
        // A channel being aborted this cycle must not win a grant.
        assign elig[g] = (st[g] == ST_ELIG) && !pend[g] && !abort_i[g] &&
                         (space_i[g*(LEN_W+1) +: LEN_W+1] >= cand[g]);
        assign busy_o[g] = (st[g] != ST_IDLE);
        assign remaining_o[g*RLEN_W +: RLEN_W] = ch_rem[g];
    end

    always_comb begin
        int idx;
        grant    = 1'b0;
        grant_ch = '0;
        idx      = 0;
        for (int k = 0; k < N_CH; k++) begin
            idx = (int'(rr_ptr) + k) % N_CH;
            if (can_grant && !grant && elig[idx]) begin
                grant    = 1'b1;
                grant_ch = CH_W'(idx);
            end
        end
    end

    // Stage p1: registered request and per-channel FSM update.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            req_valid_p1 <= 1'b0;
            req_addr_p1  <= '0;
            req_len_p1   <= '0;
            req_ch_p1    <= '0;
            rr_ptr       <= '0;
            done_q       <= '0;
            abort_pend   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                st[c]      <= ST_IDLE;
                ch_addr[c] <= '0;
                ch_rem[c]  <= '0;
            end
        end else if (cke_i) begin
            if (grant) begin
                req_valid_p1 <= 1'b1;
                req_addr_p1  <= ch_addr[grant_ch];
                req_len_p1   <= cand[grant_ch];
                req_ch_p1    <= grant_ch;
                rr_ptr       <= (grant_ch == CH_W'(N_CH - 1)) ? '0 : grant_ch + 1'b1;
            end else if (hs) begin
                req_valid_p1 <= 1'b0;
            end
            for (int c = 0; c < N_CH; c++) begin
                done_q[c] <= 1'b0;
                case (st[c])
                    ST_IDLE: begin
                        if (start_i[c]) begin
                            ch_addr[c]    <= addr_i[c*ADDR_W +: ADDR_W] & ALIGN_MASK;
                            ch_rem[c]     <= length_i[c*RLEN_W +: RLEN_W];
                            abort_pend[c] <= 1'b0;
                            if (length_i[c*RLEN_W +: RLEN_W] == '0) done_q[c] <= 1'b1;
                            else                                    st[c]     <= ST_ELIG;
                        end
                    end
                    ST_ELIG: begin
                        if (hs && (req_ch_p1 == CH_W'(c))) begin
                            st[c]      <= ST_WAIT;
                            ch_rem[c]  <= ch_rem[c] - RLEN_W'(req_len_p1);
                            ch_addr[c] <= ch_addr[c] + (ADDR_W'(req_len_p1) << OFF_W);
                            if (abort_i[c]) abort_pend[c] <= 1'b1;
                        end else if (abort_i[c]) begin
                            if (pend[c]) begin
                                abort_pend[c] <= 1'b1;
                            end else begin
                                st[c]     <= ST_IDLE;
                                done_q[c] <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (burst_done_i[c]) begin
                            if (abort_pend[c] || abort_i[c] || (ch_rem[c] == '0)) begin
                                st[c]         <= ST_IDLE;
                                done_q[c]     <= 1'b1;
                                abort_pend[c] <= 1'b0;
                            end else begin
                                st[c] <= ST_ELIG;
                            end
                        end else if (abort_i[c]) begin
                            abort_pend[c] <= 1'b1;
                        end
                    end
                    default: st[c] <= ST_IDLE;
                endcase
            end
        end
    end

    assign done_o      = done_q;
    assign req_valid_o = req_valid_p1;
    assign req_addr_o  = req_addr_p1;
    assign req_len_o   = req_len_p1;
    assign req_ch_o    = req_ch_p1;

endmodule
